// File: rtl/operand_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer_if
//  Purpose  : Operand/result bus between the front panel and the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface operand_sequencer_if;
    logic        enter;
    logic [7:0]  inputdata;
    logic        loaddata;
    logic [31:0] dataR;
    logic        done;
    logic        start;
    logic        inputdata_ready;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [7:0]  dataoutput;
    logic [1:0]  byte_sel;

    modport master (
        output enter, inputdata, loaddata, dataR, done,
        input  start, inputdata_ready, dataA, dataB, dataoutput, byte_sel
    );

    modport slave (
        input  enter, inputdata, loaddata, dataR, done,
        output start, inputdata_ready, dataA, dataB, dataoutput, byte_sel
    );
endinterface
`default_nettype wire

// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer
//  Purpose  : Builds two 32-bit operands from button presses, launches the
//             datapath and steps the result out one byte per press.
//  Revision : 1.0  initial release
// ============================================================================
module operand_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    operand_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_WAIT_R = 2'd2,
        S_SHOW_R = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [1:0]             r_idx;
    logic [1:0]             r_byte_sel;
    logic [31:0]            r_res;
    logic [31:0]            r_data_a;
    logic [31:0]            r_data_b;
    logic [7:0]             r_dout;
    logic [7:0]             r_last_byte;
    logic                   r_start;
    logic                   r_ready;

    logic                   w_enter_pulse;
    logic                   w_load_write;
    logic [1:0]             w_sel_next;

    assign w_enter_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;
    assign w_load_write  = w_enter_pulse & bus.loaddata;
    assign w_sel_next    = r_byte_sel + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.enter};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_LOAD_A;
            r_idx       <= 2'd0;
            r_byte_sel  <= 2'd0;
            r_res       <= 32'd0;
            r_data_a    <= 32'd0;
            r_data_b    <= 32'd0;
            r_dout      <= 8'd0;
            r_last_byte <= 8'd0;
            r_start     <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_LOAD_A: begin
                    if (w_load_write) begin
                        r_data_a[8*r_idx +: 8] <= bus.inputdata;
                        r_dout                 <= bus.inputdata;
                        r_last_byte            <= bus.inputdata;
                        r_idx                  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= S_LOAD_B;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_load_write) begin
                        r_data_b[8*r_idx +: 8] <= bus.inputdata;
                        r_dout                 <= bus.inputdata;
                        r_last_byte            <= bus.inputdata;
                        r_idx                  <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= S_WAIT_R;
                            r_ready <= 1'b1;
                            r_start <= 1'b1;
                        end
                    end
                end
                S_WAIT_R: begin
                    // Presses here are dropped, including one coincident with done.
                    if (bus.done) begin
                        r_res      <= bus.dataR;
                        r_dout     <= bus.dataR[7:0];
                        r_byte_sel <= 2'd0;
                        r_state    <= S_SHOW_R;
                    end
                end
                S_SHOW_R: begin
                    if (w_enter_pulse) begin
                        if (bus.loaddata) begin
                            r_state    <= S_LOAD_A;
                            r_idx      <= 2'd0;
                            r_byte_sel <= 2'd0;
                            r_ready    <= 1'b0;
                            r_dout     <= r_last_byte;
                        end else begin
                            r_byte_sel <= w_sel_next;
                            r_dout     <= r_res[8*w_sel_next +: 8];
                        end
                    end
                end
                default: r_state <= S_LOAD_A;
            endcase
        end
    end

    assign bus.start           = r_start;
    assign bus.inputdata_ready = r_ready;
    assign bus.dataA           = r_data_a;
    assign bus.dataB           = r_data_b;
    assign bus.dataoutput      = r_dout;
    assign bus.byte_sel        = r_byte_sel;

endmodule
`default_nettype wire
